// File: rtl/avalon_sdr_pkg.sv
// rtl/avalon_sdr_pkg.sv - shared widths and handshake state type for the SDR responder
package avalon_sdr_pkg;

    localparam int DATA_W = 16;
    localparam int BE_W   = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STALL,
        ACCEPT
    } sdr_state_e;

endpackage

// File: rtl/sdr_rd_pipe.sv
// rtl/sdr_rd_pipe.sv - fixed-latency read return shift register, valid bits reset only
module sdr_rd_pipe #(
    parameter int LATENCY = 3,
    parameter int WIDTH   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    // Stage 0 captures on the acceptance edge; stage LATENCY drives the return.
    logic [LATENCY:0] vld_q;
    logic [WIDTH-1:0] dat_q [LATENCY+1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_valid;
            for (int i = 1; i <= LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        dat_q[0] <= in_data;
        for (int i = 1; i <= LATENCY; i++) begin
            dat_q[i] <= dat_q[i-1];
        end
    end

    assign out_valid = vld_q[LATENCY];
    assign out_data  = dat_q[LATENCY];

endmodule

// File: rtl/avalon_sdr_responder.sv
// rtl/avalon_sdr_responder.sv - Avalon-MM SDRAM stand-in with wait states and pipelined reads
module avalon_sdr_responder
    import avalon_sdr_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int WAIT_CYCLES  = 2,
    parameter int READ_LATENCY = 3,
    parameter int MAX_PENDING  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] avs_s0_address,
    input  logic              avs_s0_read,
    input  logic              avs_s0_write,
    input  logic [DATA_W-1:0] avs_s0_writedata,
    input  logic [BE_W-1:0]   avs_s0_byteenable,
    output logic              avs_s0_waitrequest,
    output logic [DATA_W-1:0] avs_s0_readdata,
    output logic              avs_s0_readdatavalid,
    output logic              proto_err
);

    localparam int DEPTH  = 2**ADDR_W;
    localparam int WCNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int PEND_W = $clog2(MAX_PENDING + 1);
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(WAIT_CYCLES);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    sdr_state_e        state_q, state_d;
    logic              proto_q, proto_d;
    logic              live_q;
    logic              req, rd_only, wait_done, stall_full, wait_req;
    logic              accept, rd_acc, wr_acc, ret_valid;
    logic [DATA_W-1:0] ret_data;
    logic [7:0]        mem_lo [DEPTH];
    logic [7:0]        mem_hi [DEPTH];

    // wcnt saturates at WAIT_CYCLES, so "below WAIT_CYCLES" is simply "not saturated".
    always_comb begin
        req        = avs_s0_read | avs_s0_write;
        rd_only    = avs_s0_read & ~avs_s0_write;
        wait_done  = (wcnt_q == WCNT_MAX);
        stall_full = rd_only & (pend_q == PEND_MAX);
        wait_req   = ~live_q | (req & (~wait_done | stall_full));
        accept     = req & ~wait_req;
        rd_acc     = accept & rd_only;
        wr_acc     = accept & avs_s0_write;
    end

    always_comb begin
        wcnt_d = wcnt_q;
        if (!req || accept) begin
            wcnt_d = '0;
        end else if (!wait_done) begin
            wcnt_d = wcnt_q + 1'b1;
        end
        pend_d = pend_q + PEND_W'(rd_acc) - PEND_W'(ret_valid);
        if (!req) begin
            state_d = IDLE;
        end else if (accept) begin
            state_d = ACCEPT;
        end else if (wait_done) begin
            state_d = STALL;
        end else begin
            state_d = WAIT;
        end
        proto_d = proto_q | (avs_s0_read & avs_s0_write)
                | (~req & ((state_q == WAIT) | (state_q == STALL)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt_q  <= '0;
            pend_q  <= '0;
            state_q <= IDLE;
            proto_q <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            wcnt_q  <= wcnt_d;
            pend_q  <= pend_d;
            state_q <= state_d;
            proto_q <= proto_d;
            live_q  <= 1'b1;
        end
    end

    // Two byte-wide arrays give the per-lane write enables the block RAM needs.
    always_ff @(posedge clk) begin
        if (wr_acc && avs_s0_byteenable[0]) begin
            mem_lo[avs_s0_address] <= avs_s0_writedata[7:0];
        end
        if (wr_acc && avs_s0_byteenable[1]) begin
            mem_hi[avs_s0_address] <= avs_s0_writedata[15:8];
        end
    end

    sdr_rd_pipe #(
        .LATENCY (READ_LATENCY),
        .WIDTH   (DATA_W)
    ) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_acc),
        .in_data   ({mem_hi[avs_s0_address], mem_lo[avs_s0_address]}),
        .out_valid (ret_valid),
        .out_data  (ret_data)
    );

    assign avs_s0_waitrequest   = wait_req;
    assign avs_s0_readdatavalid = ret_valid;
    assign avs_s0_readdata      = ret_valid ? ret_data : '0;
    assign proto_err            = proto_q;

endmodule

// File: tb/tb_avalon_sdr_responder.sv
// tb/tb_avalon_sdr_responder.sv - bench for default and pending-limit responder configurations
module tb_avalon_sdr_responder;
    import avalon_sdr_pkg::*;

    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] data;
    } ret_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [9:0]        addr  [2];
    logic              rd_r  [2];
    logic              wr_r  [2];
    logic [DATA_W-1:0] wdata [2];
    logic [BE_W-1:0]   be    [2];
    logic              wreq  [2];
    logic [DATA_W-1:0] rdata [2];
    logic              rdv   [2];
    logic              perr  [2];

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_acc [2];
    int   n_ret [2];
    int   max_out = 0;
    ret_t rq0[$], rq1[$], eq0[$], eq1[$];
    ret_t mon_r;
    logic [DATA_W-1:0] ref_mem [2][1024];

    avalon_sdr_responder u_dut0 (
        .clk(clk), .reset(reset), .avs_s0_address(addr[0]), .avs_s0_read(rd_r[0]),
        .avs_s0_write(wr_r[0]), .avs_s0_writedata(wdata[0]), .avs_s0_byteenable(be[0]),
        .avs_s0_waitrequest(wreq[0]), .avs_s0_readdata(rdata[0]),
        .avs_s0_readdatavalid(rdv[0]), .proto_err(perr[0])
    );

    avalon_sdr_responder #(
        .ADDR_W(10), .WAIT_CYCLES(0), .READ_LATENCY(6), .MAX_PENDING(2)
    ) u_dut1 (
        .clk(clk), .reset(reset), .avs_s0_address(addr[1]), .avs_s0_read(rd_r[1]),
        .avs_s0_write(wr_r[1]), .avs_s0_writedata(wdata[1]), .avs_s0_byteenable(be[1]),
        .avs_s0_waitrequest(wreq[1]), .avs_s0_readdata(rdata[1]),
        .avs_s0_readdatavalid(rdv[1]), .proto_err(perr[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Return recorder: edge number of the cycle each readdatavalid is seen in.
    always @(negedge clk) begin
        if (rdv[0] === 1'b1) begin
            mon_r.cyc = cyc; mon_r.data = rdata[0]; rq0.push_back(mon_r); n_ret[0]++;
        end
        if (rdv[1] === 1'b1) begin
            mon_r.cyc = cyc; mon_r.data = rdata[1]; rq1.push_back(mon_r); n_ret[1]++;
        end
        if (n_acc[0] - n_ret[0] > max_out) max_out = n_acc[0] - n_ret[0];
    end

    function automatic int exp_wait(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic int lat(input int d);
        return (d == 0) ? 3 : 6;
    endfunction

    task automatic push_exp(input int d, input int acc);
        ret_t e;
        e.cyc  = acc + lat(d);
        e.data = ref_mem[d][addr[d]];
        if (d == 0) eq0.push_back(e); else eq1.push_back(e);
        n_acc[d]++;
    endtask

    task automatic xfer(input int d, input bit is_wr, input bit is_rd, input logic [9:0] a,
                        input logic [DATA_W-1:0] dat, input logic [BE_W-1:0] b, input string nm);
        int waits;
        int acc;
        addr[d] = a; wdata[d] = dat; be[d] = b; wr_r[d] = is_wr; rd_r[d] = is_rd;
        waits = 0;
        @(negedge clk);
        while (wreq[d] !== 1'b0 && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        acc = cyc + 1;
        n_checks++;
        if (waits != exp_wait(d)) begin
            n_fail++;
            $display("FAIL %s: waitrequest cycles %0d, expected %0d", nm, waits, exp_wait(d));
        end
        if (waits < 40) begin
            if (is_wr) begin
                if (b[0]) ref_mem[d][a][7:0]  = dat[7:0];
                if (b[1]) ref_mem[d][a][15:8] = dat[15:8];
            end else if (is_rd) begin
                push_exp(d, acc);
            end
        end
        @(posedge clk); #1;
        wr_r[d] = 1'b0; rd_r[d] = 1'b0;
    endtask

    task automatic drain(input int d, input string nm);
        int   t;
        int   ne;
        int   na;
        ret_t a_r;
        ret_t e_r;
        t  = 0;
        ne = (d == 0) ? eq0.size() : eq1.size();
        while (((d == 0) ? rq0.size() : rq1.size()) < ne && t < 100) begin
            @(negedge clk); t++;
        end
        repeat (8) @(negedge clk);
        na = (d == 0) ? rq0.size() : rq1.size();
        n_checks++;
        if (na != ne) begin
            n_fail++;
            $display("FAIL %s_count: %0d returns, expected %0d", nm, na, ne);
        end
        for (int i = 0; i < ne && i < na; i++) begin
            if (d == 0) begin a_r = rq0.pop_front(); e_r = eq0.pop_front(); end
            else        begin a_r = rq1.pop_front(); e_r = eq1.pop_front(); end
            n_checks++;
            if (a_r.data !== e_r.data || a_r.cyc != e_r.cyc) begin
                n_fail++;
                $display("FAIL %s_ret%0d: data %h at edge %0d, expected %h at edge %0d",
                         nm, i, a_r.data, a_r.cyc, e_r.data, e_r.cyc);
            end
        end
        if (d == 0) begin rq0.delete(); eq0.delete(); end
        else        begin rq1.delete(); eq1.delete(); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (wreq[d] !== 1'b1 || rdv[d] !== 1'b0 || rdata[d] !== 16'h0 || perr[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_values dut%0d: wreq=%b rdv=%b rdata=%h perr=%b, expected 1 0 0000 0",
                         d, wreq[d], rdv[d], rdata[d], perr[d]);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        xfer(0, 1'b1, 1'b0, 10'd5, 16'hDEAD, 2'b11, "single_wr");
        xfer(0, 1'b0, 1'b1, 10'd5, 16'h0, 2'b00, "single_rd");
        drain(0, "single");
    endtask

    task automatic test_pattern();
        max_out = 0;
        for (int i = 0; i < 14; i++)
            xfer(0, 1'b1, 1'b0, 10'(i), (i % 2 == 1) ? 16'hDEAD : 16'hBEEF, 2'b11, "pattern_wr");
        for (int i = 0; i < 14; i++)
            xfer(0, 1'b0, 1'b1, 10'(i), 16'h0, 2'b00, "pattern_rd");
        drain(0, "pattern");
        n_checks++;
        if (max_out > 4) begin
            n_fail++;
            $display("FAIL pattern_pending: outstanding reached %0d, limit 4", max_out);
        end
    endtask

    task automatic test_byte_enable();
        xfer(0, 1'b1, 1'b0, 10'd7, 16'hDEAD, 2'b11, "be_full");
        xfer(0, 1'b1, 1'b0, 10'd7, 16'h12FF, 2'b01, "be_low");
        xfer(0, 1'b0, 1'b1, 10'd7, 16'h0, 2'b00, "be_rd1");
        xfer(0, 1'b1, 1'b0, 10'd7, 16'hABCD, 2'b00, "be_none");
        xfer(0, 1'b0, 1'b1, 10'd7, 16'h0, 2'b00, "be_rd2");
        drain(0, "byte_enable");
    endtask

    task automatic test_random();
        for (int a = 16; a < 24; a++)
            xfer(0, 1'b1, 1'b0, 10'(a), 16'($urandom), 2'b11, "rand_init");
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1)
                xfer(0, 1'b1, 1'b0, 10'(16 + $urandom_range(0, 7)), 16'($urandom),
                     2'($urandom_range(0, 3)), "rand_wr");
            else
                xfer(0, 1'b0, 1'b1, 10'(16 + $urandom_range(0, 7)), 16'h0, 2'b00, "rand_rd");
        end
        drain(0, "random");
        n_checks++;
        if (perr[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL random_proto: proto_err %b, expected 0", perr[0]);
        end
    endtask

    task automatic test_pending_limit();
        int acc [3];
        int k;
        int t;
        xfer(1, 1'b1, 1'b0, 10'd20, 16'h5A3C, 2'b11, "pend_wr");
        k = 0; t = 0;
        addr[1] = 10'd20; rd_r[1] = 1'b1;
        while (k < 3 && t < 40) begin
            @(negedge clk); t++;
            if (wreq[1] === 1'b0) begin
                acc[k] = cyc + 1;
                push_exp(1, acc[k]);
                k++;
                if (k == 3) begin @(posedge clk); #1; rd_r[1] = 1'b0; end
            end
        end
        rd_r[1] = 1'b0;
        n_checks++;
        if (k != 3 || acc[1] - acc[0] != 1 || acc[2] - acc[0] != 8) begin
            n_fail++;
            $display("FAIL pending_limit: %0d accepts, offsets %0d %0d, expected 3 accepts at 1 8",
                     k, acc[1] - acc[0], acc[2] - acc[0]);
        end
        drain(1, "pending");
    endtask

    task automatic test_simultaneous();
        xfer(0, 1'b1, 1'b1, 10'd3, 16'h0042, 2'b11, "rw_both");
        n_checks++;
        if (perr[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rw_proto: proto_err %b, expected 1", perr[0]);
        end
        drain(0, "rw_noread");
        xfer(0, 1'b0, 1'b1, 10'd3, 16'h0, 2'b00, "rw_rd");
        drain(0, "rw_data");
        n_checks++;
        if (perr[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL rw_sticky: proto_err %b, expected 1", perr[0]);
        end
    endtask

    task automatic test_reset_mid_read();
        int k;
        int t;
        k = 0; t = 0;
        addr[1] = 10'd20; rd_r[1] = 1'b1;
        while (k < 2 && t < 40) begin
            @(negedge clk); t++;
            if (wreq[1] === 1'b0) k++;
        end
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (rdv[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrd_first_valid: readdatavalid %b, expected 1", rdv[1]);
        end
        reset = 1'b1; rd_r[1] = 1'b0;
        #1;
        n_checks++;
        if (rdv[1] !== 1'b0 || rdata[1] !== 16'h0 || wreq[0] !== 1'b1 || wreq[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL midrd_in_reset: rdv=%b rdata=%h wreq=%b%b, expected 0 0000 11",
                     rdv[1], rdata[1], wreq[0], wreq[1]);
        end
        rq1.delete(); eq1.delete(); n_acc[1] = 0; n_ret[1] = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++;
        if (rq1.size() != 0 || perr[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL midrd_after: %0d stale returns, proto_err %b, expected 0 0", rq1.size(), perr[0]);
        end
        @(posedge clk); #1;
        xfer(1, 1'b0, 1'b1, 10'd20, 16'h0, 2'b00, "midrd_rd1");
        drain(1, "midrd_mem1");
        xfer(0, 1'b0, 1'b1, 10'd7, 16'h0, 2'b00, "midrd_rd0");
        drain(0, "midrd_mem0");
    endtask

    task automatic test_drop();
        n_checks++;
        if (perr[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_pre: proto_err %b, expected 0", perr[0]);
        end
        addr[0] = 10'd5; rd_r[0] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (wreq[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_wait: waitrequest %b, expected 1", wreq[0]);
        end
        @(posedge clk); #1;
        rd_r[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (perr[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_proto: proto_err %b, expected 1", perr[0]);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            addr[d] = '0; rd_r[d] = 1'b0; wr_r[d] = 1'b0; wdata[d] = '0; be[d] = '0;
            n_acc[d] = 0; n_ret[d] = 0;
            for (int a = 0; a < 1024; a++) ref_mem[d][a] = '0;
        end
        test_reset();
        test_single();
        test_pattern();
        test_byte_enable();
        test_random();
        test_pending_limit();
        test_simultaneous();
        test_reset_mid_read();
        test_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
